// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and D-cache.
// One transaction is outstanding at a time; address, write data and operation are latched at grant.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t            state;
    logic              last_d;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              req_i;
    logic              req_d;
    logic              grant_i;
    logic              grant_d;

    // On a tie, whoever was not served last wins.
    always_comb begin
        req_i   = i_read;
        req_d   = d_read | d_write;
        grant_i = req_i & (~req_d | last_d);
        grant_d = req_d & ~grant_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_d   <= 1'b1;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state    <= SERVE_I;
                        addr_q   <= i_address;
                        op_write <= 1'b0;
                        busy     <= 1'b1;
                    end else if (grant_d) begin
                        state    <= SERVE_D;
                        addr_q   <= d_address;
                        wdata_q  <= d_wdata;
                        op_write <= d_write;
                        busy     <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state  <= IDLE;
                        last_d <= (state == SERVE_D);
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // busy is a register cleared by reset, so the memory strobes drop asynchronously with it.
    assign mem_read    = busy & ~op_write;
    assign mem_write   = busy & op_write;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_resp      = (state == SERVE_I) & mem_resp;
    assign d_resp      = (state == SERVE_D) & mem_resp;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

endmodule
